universal_shift_reg: RTL
========================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low, sampled on rising CLK.
REQ-004 Mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-005 D  input  WIDTH  parallel load data.
REQ-006 SinR  input  1  serial input entering the MSB on shift right.
REQ-007 SinL  input  1  serial input entering the LSB on shift left.
REQ-008 Q  output  WIDTH  register contents.
REQ-009 Qbar  output  WIDTH  bitwise complement of Q at all times.
REQ-010 SoutR  output  1  bit shifted out on the last shift right (previous Q[0]).
REQ-011 SoutL  output  1  bit shifted out on the last shift left (previous Q[WIDTH-1]).
REQ-012 Cnt  output  clog2(WIDTH+1)  shifts since last load or reset, saturating at WIDTH.
REQ-013 Full  output  1  high exactly when Cnt == WIDTH.

Function
REQ-014 Hold (00): Q, SoutR, SoutL and Cnt keep their values.
REQ-015 Shift right (01): Q <= {SinR, Q[WIDTH-1:1]}; SoutR <= Q[0]; SoutL holds.
REQ-016 Shift left (10): Q <= {Q[WIDTH-2:0], SinL}; SoutL <= Q[WIDTH-1]; SoutR holds.
REQ-017 Parallel load (11): Q <= D; SoutR and SoutL cleared to 0; Cnt <= 0.
REQ-018 Each shift, either direction, increments Cnt by 1; at Cnt == WIDTH it stays at WIDTH (no wrap).
REQ-019 Outputs are registered; a Mode/data change is visible on Q exactly one CLK edge later, with no combinational path from inputs to Q, Cnt or Full.
REQ-020 Qbar and Full are combinational decodes of registered state only.
REQ-021 Mode value changes between consecutive edges take effect per edge with no dead cycle; alternating 01/10 is legal.
REQ-022 After WIDTH shifts right with SinR = 0 following a load, Q == 0 and Full = 1.

Reset
REQ-023 RST_N low at a rising edge overrides Mode: Q <= 0, SoutR <= 0, SoutL <= 0, Cnt <= 0; hence Qbar all ones and Full = 0.
REQ-024 Reset asserted mid-sequence (Cnt nonzero) discards the sequence; the first edge with RST_N high resumes normal Mode decoding from the cleared state.
REQ-025 RST_N changes between edges have no effect until the next rising CLK.

Structure
REQ-026 Mode encodings (HOLD, SHR, SHL, LOAD) are defined once in shared package cpu_pkg and used by this block and its bench.
REQ-027 Storage is built from one sub-module d_ff (rising-edge D flip-flop, synchronous active-low reset, Q/Qbar outputs), instantiated per bit with a per-bit 4:1 mode multiplexer at its D input.
REQ-028 Cnt and Full logic sit in the top module.

Verification
REQ-029 RST_N=0 for one edge with Mode=11, D=8'hA5 -> Q=00, Qbar=FF, Cnt=0, Full=0.
REQ-030 Load D=8'hA5, then one Mode=01 edge with SinR=1 -> Q=D2, SoutR=1, Cnt=1.
REQ-031 Load 8'h81, then one Mode=10 edge with SinL=0 -> Q=02, SoutL=1, Cnt=1.
REQ-032 Load 8'hFF, then 10 Mode=01 edges with SinR=0 -> Q=00 after the 8th edge, Cnt saturates at 8, Full=1 from the 8th edge.
REQ-033 Load 8'h3C, then Mode=00 for 5 edges with D and SinR/SinL toggling -> Q stays 3C, Cnt stays 0.
REQ-034 After 3 shifts (Cnt=3), RST_N=0 with Mode=01 for one edge -> Q=00, Cnt=0, SoutR=0; next Mode=11 with D=8'h5A -> Q=5A.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the universal shift register and its bench.
package cpu_pkg;

  // Operation select for the universal shift register.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } mode_e;

endpackage : cpu_pkg

// File: rtl/universal_shift_reg_d_ff.sv
// Single-bit rising-edge D flip-flop with synchronous active-low reset.
module d_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic qbar
);

  // Capture d on the rising edge; reset clears the bit.
  always_ff @(posedge clk) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  // Complement is a pure decode of the stored bit.
  always_comb begin
    qbar = ~q;
  end

endmodule : d_ff

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with serial-out capture and a saturating shift counter.
module universal_shift_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [1:0]                 Mode,
  input  logic [WIDTH-1:0]           D,
  input  logic                       SinR,
  input  logic                       SinL,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           Qbar,
  output logic                       SoutR,
  output logic                       SoutL,
  output logic [$clog2(WIDTH+1)-1:0] Cnt,
  output logic                       Full
);

  localparam int CNT_W = $clog2(WIDTH+1);

  mode_e              mode;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   qbar_r;
  logic [WIDTH-1:0]   shr_vec;
  logic [WIDTH-1:0]   shl_vec;
  logic               sout_r_q;
  logic               sout_l_q;
  logic [CNT_W-1:0]   cnt_q;

  // Decode the raw mode bits and form both shifted candidates.
  always_comb begin
    mode    = mode_e'(Mode);
    shr_vec = {SinR, q_r[WIDTH-1:1]};
    shl_vec = {q_r[WIDTH-2:0], SinL};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic mux_out;

    // Per-bit 4:1 mode multiplexer feeding the storage flop.
    always_comb begin
      mux_out = q_r[i];
      unique case (mode)
        HOLD: mux_out = q_r[i];
        SHR:  mux_out = shr_vec[i];
        SHL:  mux_out = shl_vec[i];
        LOAD: mux_out = D[i];
      endcase
    end

    d_ff u_d_ff (
      .clk  (CLK),
      .rst_n(RST_N),
      .d    (mux_out),
      .q    (q_r[i]),
      .qbar (qbar_r[i])
    );
  end

  // Serial-out capture: each side updates only on its own shift direction.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sout_r_q <= 1'b0;
      sout_l_q <= 1'b0;
    end else begin
      unique case (mode)
        HOLD: ;
        SHR:  sout_r_q <= q_r[0];
        SHL:  sout_l_q <= q_r[WIDTH-1];
        LOAD: begin
          sout_r_q <= 1'b0;
          sout_l_q <= 1'b0;
        end
      endcase
    end
  end

  // Shift counter: cleared by reset/load, saturates at WIDTH.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      unique case (mode)
        HOLD: ;
        SHR, SHL: if (cnt_q != CNT_W'(WIDTH)) cnt_q <= cnt_q + CNT_W'(1);
        LOAD: cnt_q <= '0;
      endcase
    end
  end

  // Output decodes of registered state only.
  always_comb begin
    Q     = q_r;
    Qbar  = qbar_r;
    SoutR = sout_r_q;
    SoutL = sout_l_q;
    Cnt   = cnt_q;
    Full  = (cnt_q == CNT_W'(WIDTH));
  end

endmodule : universal_shift_reg
